// File: rtl/mux_rr_arbiter.sv
// Purpose:      N-to-1 arbitrating mux, round-robin or fixed-priority, into a one-word output register.
// Latency:      1 cycle from grant (in_ready high) to out_valid.
// Backpressure: a held word (out_valid & ~out_ready) freezes the output and blocks all grants.
//
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   prio_mode   0 = round-robin starting at the rotating pointer, 1 = lowest index wins
//   in_valid    per-channel request, bit i = channel i
//   in_data     channel i word at [i*WIDTH +: WIDTH]
//   in_ready    one-hot grant (or zero); channel i transfers when its bit is high
//   out_valid   out_data/out_sel hold a valid word
//   out_data    registered word of the granted channel
//   out_sel     index of the channel that supplied out_data
//   out_ready   downstream accepts when out_valid & out_ready
module mux_rr_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 prio_mode,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);

    logic [SELW-1:0]  ptr;
    logic             load;
    logic             any_req;
    logic             grant;

    // Lowest requester overall, and lowest requester at or above ptr.
    logic             fp_found;
    logic [SELW-1:0]  fp_idx;
    logic             hi_found;
    logic [SELW-1:0]  hi_idx;

    logic [SELW-1:0]  g;
    logic [SELW-1:0]  ptr_nxt;
    logic [WIDTH-1:0] sel_data;

    // The output register can take a new word when it is empty or being drained.
    assign load    = (~out_valid | out_ready) & ~rst;
    assign any_req = |in_valid;
    assign grant   = load & any_req;

    // Scan downwards so the last hit is the lowest index. The round-robin order
    // ptr..N-1, 0..ptr-1 is the first requester at/above ptr, otherwise the
    // lowest requester overall (which must then sit below ptr).
    always_comb begin
        fp_found = 1'b0;
        fp_idx   = '0;
        hi_found = 1'b0;
        hi_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                fp_found = 1'b1;
                fp_idx   = SELW'(i);
            end
            if (in_valid[i] && (i >= int'(ptr))) begin
                hi_found = 1'b1;
                hi_idx   = SELW'(i);
            end
        end
    end

    always_comb begin
        g = fp_idx;
        if (!prio_mode && hi_found) begin
            g = hi_idx;
        end
    end

    // Pointer wraps explicitly so non-power-of-two N never lands on an unused index.
    always_comb begin
        ptr_nxt = '0;
        if (g != SELW'(N - 1)) begin
            ptr_nxt = g + SELW'(1);
        end
    end

    always_comb begin
        in_ready = '0;
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (g == SELW'(i)) begin
                in_ready[i] = grant;
                sel_data    = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (fp_found) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_sel   <= g;
                if (!prio_mode) begin
                    ptr <= ptr_nxt;
                end
            end else begin
                // Idle drain: data and index keep their last values.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Purpose:      self-checking bench for mux_rr_arbiter (N=4, WIDTH=8).
// Latency:      every step drives inputs at negedge, checks in_ready, then checks outputs after posedge.
// Backpressure: out_ready is driven directly per step; no waits on DUT events.
module tb_mux_rr_arbiter;

    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam int SELW  = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               prio_mode;
    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_sel;
    logic               out_ready;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int             m_ptr;
    logic           m_valid;
    logic [7:0]     m_data;
    int             m_sel;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .prio_mode (prio_mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check grant combinationally, clock, check outputs.
    task automatic step(input logic r, input logic pm, input logic [3:0] v,
                        input logic [31:0] d, input logic ordy);
        logic       ld;
        logic       found;
        int         g;
        int         idx;
        logic [3:0] exp_rdy;
        @(negedge clk);
        rst       = r;
        prio_mode = pm;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        ld    = (!m_valid || ordy) && !r;
        found = 1'b0;
        g     = 0;
        if (ld) begin
            for (int k = 0; k < N; k++) begin
                idx = pm ? k : (m_ptr + k) % N;
                if (!found && v[idx]) begin
                    found = 1'b1;
                    g     = idx;
                end
            end
        end
        exp_rdy = found ? 4'(1 << g) : 4'b0000;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_sel   = 0;
            m_ptr   = 0;
        end else if (ld) begin
            if (found) begin
                m_valid = 1'b1;
                m_data  = d[g*8 +: 8];
                m_sel   = g;
                if (!pm) m_ptr = (g + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("out_sel",   32'(out_sel),   32'(m_sel));
    endtask

    initial begin
        logic [31:0] da;
        da = 32'hA3A2A1A0;
        m_ptr = 0; m_valid = 1'b0; m_data = 8'h00; m_sel = 0;
        rst = 1'b1; prio_mode = 1'b0; in_valid = 4'hF; in_data = da; out_ready = 1'b1;

        // Reset with all requests up
        step(1, 0, 4'hF, da, 1);
        step(1, 0, 4'hF, da, 1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sel",   32'(out_sel),   32'd0);

        // Round-robin fairness: 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 4'hF, da, 1);
            chk("rr_sel",  32'(out_sel),  32'(i % 4));
            chk("rr_data", 32'(out_data), 32'hA0 + 32'(i % 4));
        end

        // Sparse wrap: grant 2 (ptr->3), then 0011 gives 0 then 1
        step(0, 0, 4'b0100, da, 1);
        step(0, 0, 4'b0011, da, 1);
        chk("wrap_g0", 32'(out_sel), 32'd0);
        step(0, 0, 4'b0011, da, 1);
        chk("wrap_g1", 32'(out_sel), 32'd1);

        // Backpressure: hold channel 2 word for 3 cycles, then release
        step(0, 0, 4'b0100, da, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 4'hF, da, 0);
            chk("bp_sel",   32'(out_sel),   32'd2);
            chk("bp_valid", 32'(out_valid), 32'd1);
        end
        step(0, 0, 4'hF, da, 1);
        chk("bp_next", 32'(out_sel), 32'd3);

        // Fixed priority with ptr parked at 0
        step(0, 0, 4'b1000, da, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 4'b1010, da, 1);
            chk("fp_sel", 32'(out_sel), 32'd1);
        end
        step(0, 0, 4'b1010, da, 1);
        chk("fp_resume", 32'(out_sel), 32'd1);

        // Idle drain
        step(0, 0, 4'b0001, da, 1);
        step(0, 0, 4'b0000, da, 1);
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_data",  32'(out_data),  32'hA0);
        step(0, 0, 4'b0000, da, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 40) == 0, ($urandom % 4) == 0, 4'($urandom),
                 $urandom, ($urandom % 4) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
